mcpu_core_scoreboard: RTL and testbench

Tracks outstanding register and predicate writes for the core pipeline and drives `sb2d_reg_scoreboard` / `sb2d_pred_scoreboard` into decode.
- A pending bit is set when a bundle issues out of decode with a write enable.
- The bit is cleared when that write retires at writeback.
- Decode combines these vectors with its own dependency flags to form `dep_stall`.
- The block sits beside decode, fed by decode outputs at issue and by the writeback stage.

---
 rtl/mcpu_core_scoreboard_if.sv | 30 +++
 rtl/mcpu_core_scoreboard.sv | 75 +++++++
 tb/tb_mcpu_core_scoreboard.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_scoreboard_if.sv
// Decode/writeback to scoreboard bundle: issue-time sets, writeback clears and flush in;
// pending vectors out to decode. No handshake; every field is sampled every cycle.
interface mcpu_core_scoreboard_if #(
   parameter int NUM_LANES = 4
);
   logic                   d2sb_issue;
   logic [NUM_LANES-1:0]   d2sb_lane_valid;
   logic [NUM_LANES-1:0]   d2sb_rd_we;
   logic [NUM_LANES-1:0]   d2sb_pred_we;
   logic [5*NUM_LANES-1:0] d2sb_rd_num;
   logic [NUM_LANES-1:0]   wb2sb_rd_we;
   logic [NUM_LANES-1:0]   wb2sb_pred_we;
   logic [5*NUM_LANES-1:0] wb2sb_rd_num;
   logic                   pc2sb_flush;
   logic [31:0]            sb2d_reg_scoreboard;
   logic [2:0]             sb2d_pred_scoreboard;
   logic                   sb_busy;

   modport master (
      output d2sb_issue, d2sb_lane_valid, d2sb_rd_we, d2sb_pred_we, d2sb_rd_num,
      output wb2sb_rd_we, wb2sb_pred_we, wb2sb_rd_num, pc2sb_flush,
      input  sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_busy
   );

   modport slave (
      input  d2sb_issue, d2sb_lane_valid, d2sb_rd_we, d2sb_pred_we, d2sb_rd_num,
      input  wb2sb_rd_we, wb2sb_pred_we, wb2sb_rd_num, pc2sb_flush,
      output sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_busy
   );
endinterface

// File: rtl/mcpu_core_scoreboard.sv
// Pending-write scoreboard for registers and predicates 0..2; sets visible one cycle after issue,
// clears same-cycle when WB_BYPASS=1 else next cycle. Never stalls, accepts inputs every cycle.
module mcpu_core_scoreboard #(
   parameter int NUM_LANES = 4,
   parameter bit WB_BYPASS = 1'b1
) (
   input logic                   clkrst_core_clk,
   input logic                   clkrst_core_rst,
   mcpu_core_scoreboard_if.slave sb
);

   logic [31:0] reg_pend;
   logic [2:0]  pred_pend;
   logic [31:0] set_reg;
   logic [31:0] clr_reg;
   logic [2:0]  set_pred;
   logic [2:0]  clr_pred;
   logic [31:0] reg_next;
   logic [2:0]  pred_next;

   // Predicate 3 is constant-true, so only indices 0..2 are ever decoded.
   always_comb begin
      set_reg  = '0;
      clr_reg  = '0;
      set_pred = '0;
      clr_pred = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (sb.d2sb_issue && sb.d2sb_lane_valid[i]) begin
            if (sb.d2sb_rd_we[i])
               set_reg[sb.d2sb_rd_num[5*i +: 5]] = 1'b1;
            for (int p = 0; p < 3; p++)
               if (sb.d2sb_pred_we[i] && (sb.d2sb_rd_num[5*i +: 2] == 2'(p)))
                  set_pred[p] = 1'b1;
         end
         if (sb.wb2sb_rd_we[i])
            clr_reg[sb.wb2sb_rd_num[5*i +: 5]] = 1'b1;
         for (int p = 0; p < 3; p++)
            if (sb.wb2sb_pred_we[i] && (sb.wb2sb_rd_num[5*i +: 2] == 2'(p)))
               clr_pred[p] = 1'b1;
      end
   end

   // Set beats clear: the issuing writer is younger than the one retiring.
   always_comb begin
      reg_next  = (reg_pend & ~clr_reg) | set_reg;
      pred_next = (pred_pend & ~clr_pred) | set_pred;
      if (sb.pc2sb_flush) begin
         reg_next  = '0;
         pred_next = '0;
      end
   end

   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         reg_pend  <= '0;
         pred_pend <= '0;
      end else begin
         reg_pend  <= reg_next;
         pred_pend <= pred_next;
      end
   end

   generate
      if (WB_BYPASS) begin : g_bypass
         assign sb.sb2d_reg_scoreboard  = reg_pend & ~clr_reg;
         assign sb.sb2d_pred_scoreboard = pred_pend & ~clr_pred;
      end else begin : g_registered
         assign sb.sb2d_reg_scoreboard  = reg_pend;
         assign sb.sb2d_pred_scoreboard = pred_pend;
      end
   endgenerate

   assign sb.sb_busy = (|reg_pend) | (|pred_pend);

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Bench for mcpu_core_scoreboard: one bypass and one registered instance share stimulus;
// expected outputs come from a bench-side pending model through an expectation queue.
module tb_mcpu_core_scoreboard;

   localparam int NL = 4;

   typedef struct packed {
      logic [31:0] reg_byp;
      logic [2:0]  pred_byp;
      logic [31:0] reg_reg;
      logic [2:0]  pred_reg;
      logic        busy;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   logic [31:0] m_reg;
   logic [2:0]  m_pred;
   exp_t        exp_q[$];

   mcpu_core_scoreboard_if #(.NUM_LANES(NL)) sb_b();
   mcpu_core_scoreboard_if #(.NUM_LANES(NL)) sb_r();

   assign sb_r.d2sb_issue      = sb_b.d2sb_issue;
   assign sb_r.d2sb_lane_valid = sb_b.d2sb_lane_valid;
   assign sb_r.d2sb_rd_we      = sb_b.d2sb_rd_we;
   assign sb_r.d2sb_pred_we    = sb_b.d2sb_pred_we;
   assign sb_r.d2sb_rd_num     = sb_b.d2sb_rd_num;
   assign sb_r.wb2sb_rd_we     = sb_b.wb2sb_rd_we;
   assign sb_r.wb2sb_pred_we   = sb_b.wb2sb_pred_we;
   assign sb_r.wb2sb_rd_num    = sb_b.wb2sb_rd_num;
   assign sb_r.pc2sb_flush     = sb_b.pc2sb_flush;

   mcpu_core_scoreboard #(.NUM_LANES(NL), .WB_BYPASS(1'b1)) dut_byp (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .sb              (sb_b)
   );

   mcpu_core_scoreboard #(.NUM_LANES(NL), .WB_BYPASS(1'b0)) dut_reg (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .sb              (sb_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic clear_inputs();
      sb_b.d2sb_issue      = 1'b0;
      sb_b.d2sb_lane_valid = '0;
      sb_b.d2sb_rd_we      = '0;
      sb_b.d2sb_pred_we    = '0;
      sb_b.d2sb_rd_num     = '0;
      sb_b.wb2sb_rd_we     = '0;
      sb_b.wb2sb_pred_we   = '0;
      sb_b.wb2sb_rd_num    = '0;
      sb_b.pc2sb_flush     = 1'b0;
   endtask

   task automatic set_issue(input int lane, input logic rwe, input logic pwe, input logic [4:0] rd);
      sb_b.d2sb_issue               = 1'b1;
      sb_b.d2sb_lane_valid[lane]    = 1'b1;
      sb_b.d2sb_rd_we[lane]         = rwe;
      sb_b.d2sb_pred_we[lane]       = pwe;
      sb_b.d2sb_rd_num[5*lane +: 5] = rd;
   endtask

   task automatic set_wb(input int lane, input logic rwe, input logic pwe, input logic [4:0] rd);
      sb_b.wb2sb_rd_we[lane]         = rwe;
      sb_b.wb2sb_pred_we[lane]       = pwe;
      sb_b.wb2sb_rd_num[5*lane +: 5] = rd;
   endtask

   // One cycle: predict outputs for the current inputs, compare mid-cycle, advance the model.
   task automatic step();
      logic [31:0] s_r, c_r;
      logic [3:0]  s_p, c_p;
      logic [4:0]  rd;
      exp_t        e;
      s_r = '0; c_r = '0; s_p = '0; c_p = '0;
      for (int i = 0; i < NL; i++) begin
         if (sb_b.d2sb_issue && sb_b.d2sb_lane_valid[i]) begin
            rd = sb_b.d2sb_rd_num[5*i +: 5];
            if (sb_b.d2sb_rd_we[i])   s_r[rd] = 1'b1;
            if (sb_b.d2sb_pred_we[i]) s_p[rd[1:0]] = 1'b1;
         end
         rd = sb_b.wb2sb_rd_num[5*i +: 5];
         if (sb_b.wb2sb_rd_we[i])   c_r[rd] = 1'b1;
         if (sb_b.wb2sb_pred_we[i]) c_p[rd[1:0]] = 1'b1;
      end
      e.reg_byp  = m_reg & ~c_r;
      e.pred_byp = m_pred & ~c_p[2:0];
      e.reg_reg  = m_reg;
      e.pred_reg = m_pred;
      e.busy     = (m_reg != 0) || (m_pred != 0);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("reg_byp",  sb_b.sb2d_reg_scoreboard,          e.reg_byp);
      chk("pred_byp", {29'd0, sb_b.sb2d_pred_scoreboard}, {29'd0, e.pred_byp});
      chk("reg_reg",  sb_r.sb2d_reg_scoreboard,          e.reg_reg);
      chk("pred_reg", {29'd0, sb_r.sb2d_pred_scoreboard}, {29'd0, e.pred_reg});
      chk("busy",     {31'd0, sb_b.sb_busy},             {31'd0, e.busy});
      chk("busy_reg", {31'd0, sb_r.sb_busy},             {31'd0, e.busy});
      @(posedge clk);
      if (sb_b.pc2sb_flush) begin
         m_reg  = '0;
         m_pred = '0;
      end else begin
         m_reg  = (m_reg & ~c_r) | s_r;
         m_pred = ((m_pred & ~c_p[2:0]) | s_p[2:0]);
      end
      #1;
      clear_inputs();
   endtask

   task automatic peek(input string tag, input logic [31:0] rb, input logic [31:0] rr,
                       input logic [2:0] pb, input logic [2:0] pr, input logic bz);
      #1;
      chk({tag, "_reg_byp"},  sb_b.sb2d_reg_scoreboard, rb);
      chk({tag, "_reg_reg"},  sb_r.sb2d_reg_scoreboard, rr);
      chk({tag, "_pred_byp"}, {29'd0, sb_b.sb2d_pred_scoreboard}, {29'd0, pb});
      chk({tag, "_pred_reg"}, {29'd0, sb_r.sb2d_pred_scoreboard}, {29'd0, pr});
      chk({tag, "_busy"},     {31'd0, sb_b.sb_busy}, {31'd0, bz});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      m_reg  = '0;
      m_pred = '0;
      rst    = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      peek("reset", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step();

      // issue r5, then bypassed writeback clear on lane 2
      set_issue(0, 1'b1, 1'b0, 5'd5);
      step();
      peek("r5_set", 32'h20, 32'h20, 3'b000, 3'b000, 1'b1);
      set_wb(2, 1'b1, 1'b0, 5'd5);
      peek("r5_wb", 32'h0, 32'h20, 3'b000, 3'b000, 1'b1);
      step();
      peek("r5_gone", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);

      // unqualified issue attempts
      set_issue(0, 1'b1, 1'b0, 5'd7);
      sb_b.d2sb_issue = 1'b0;
      step();
      set_issue(1, 1'b1, 1'b0, 5'd7);
      sb_b.d2sb_lane_valid = '0;
      step();
      peek("no_issue", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);

      // set wins over same-cycle clear; multi-lane OR
      set_issue(0, 1'b1, 1'b0, 5'd3);
      set_wb(1, 1'b1, 1'b0, 5'd3);
      step();
      peek("r3_set_wins", 32'h8, 32'h8, 3'b000, 3'b000, 1'b1);
      set_issue(0, 1'b1, 1'b0, 5'd9);
      step();
      set_issue(0, 1'b1, 1'b0, 5'd9);
      set_issue(1, 1'b1, 1'b0, 5'd10);
      set_wb(3, 1'b1, 1'b0, 5'd9);
      step();
      peek("r9_r10", 32'h608, 32'h608, 3'b000, 3'b000, 1'b1);
      sb_b.pc2sb_flush = 1'b1;
      step();

      // predicates
      set_issue(0, 1'b0, 1'b1, 5'd2);
      step();
      peek("p2", 32'h0, 32'h0, 3'b100, 3'b100, 1'b1);
      set_issue(0, 1'b0, 1'b1, 5'd3);
      step();
      peek("p3_ignored", 32'h0, 32'h0, 3'b100, 3'b100, 1'b1);
      set_issue(1, 1'b1, 1'b1, 5'd0);
      step();
      peek("pld", 32'h1, 32'h1, 3'b101, 3'b101, 1'b1);
      set_wb(0, 1'b0, 1'b1, 5'd2);
      peek("p2_wb", 32'h1, 32'h1, 3'b001, 3'b101, 1'b1);
      step();

      // flush overrides a same-cycle issue
      sb_b.pc2sb_flush = 1'b1;
      step();
      set_issue(0, 1'b1, 1'b0, 5'd1);
      set_issue(1, 1'b1, 1'b0, 5'd31);
      set_issue(2, 1'b0, 1'b1, 5'd1);
      step();
      peek("pre_flush", 32'h80000002, 32'h80000002, 3'b010, 3'b010, 1'b1);
      sb_b.pc2sb_flush = 1'b1;
      set_issue(0, 1'b1, 1'b0, 5'd4);
      step();
      peek("flushed", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);

      // random traffic against the model
      for (int c = 0; c < 60; c++) begin
         for (int l = 0; l < NL; l++) begin
            if ($urandom_range(0, 1) == 1)
               set_issue(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 31)));
            if ($urandom_range(0, 2) == 0)
               set_wb(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)));
         end
         if ($urandom_range(0, 3) == 0) sb_b.d2sb_issue = 1'b0;
         if ($urandom_range(0, 19) == 0) sb_b.pc2sb_flush = 1'b1;
         step();
      end

      // fill every register, then async reset mid-cycle
      for (int g = 0; g < 8; g++) begin
         for (int l = 0; l < NL; l++)
            set_issue(l, 1'b1, 1'b0, 5'(4*g + l));
         step();
      end
      peek("all_set", 32'hFFFFFFFF, 32'hFFFFFFFF, m_pred, m_pred, 1'b1);
      #1;
      rst = 1'b1;
      peek("async_rst", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);
      #1;
      rst = 1'b0;
      m_reg  = '0;
      m_pred = '0;
      @(posedge clk);
      #1;
      step();

      // registered build sees a clear one cycle later
      set_issue(3, 1'b1, 1'b0, 5'd17);
      step();
      set_wb(0, 1'b1, 1'b0, 5'd17);
      peek("late_clr", 32'h0, 32'h20000, 3'b000, 3'b000, 1'b1);
      step();
      peek("late_clr_n1", 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
